div_unit: RTL and testbench
===========================

Name: div_unit

Overview:
- Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU, instantiated beside the EX stage.
- Produces the EX-stage stall request consumed by the pipeline controller. EX holds stallreq high while the divider is busy.
- Receives the controller's EX stall bit so a finished result is held while the pipeline is frozen.
- One operation in flight; 32 iteration cycles per operation.

Parameters:
- XLEN, 32, operand/result width; fixed iteration count = XLEN

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-low (asserted when rst==0)
- start_i  input  1  EX requests a divide; EX drives is_div & ~ready_o
- op_i  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU; sampled with start_i in IDLE
- dividend_i  input  XLEN  rs1 value, sampled in IDLE
- divisor_i  input  XLEN  rs2 value, sampled in IDLE
- annul_i  input  1  branch flush of the EX instruction; aborts the operation
- stall_i  input  1  stalled_o[3] from the controller (EX frozen)
- result_o  output  XLEN  quotient or remainder per latched op
- ready_o  output  1  result_o valid
- busy_o  output  1  operation in progress (CALC or DONE)
- stallreq_o  output  1  to the controller's EX stall request input

Behaviour:
- States:
  - IDLE: no operation; waits for start_i.
  - CALC: iterating; 5-bit counter runs 0..31.
  - DONE: result valid on result_o.
- Reset (rst==0 at an edge): state=IDLE, counter=0, result_o=0, ready_o=0, busy_o=0. Internal dividend/divisor/remainder/quotient registers = 0. Reset overrides everything, including mid-CALC.
- IDLE, start_i=1 and annul_i=0:
  - Latch op.
  - Signed ops: latch |dividend| and |divisor|, plus quotient sign = sign(a)^sign(b) and remainder sign = sign(a).
  - Go to CALC, counter=0.
- CALC, each cycle:
  - {rem,quo} shift left by 1.
  - If rem >= divisor: rem -= divisor and set quo LSB.
  - Compare uses XLEN+1 bits, so the unsigned magnitude 0x80000000 is handled correctly.
  - After counter==31: apply sign fixups (two's complement negate where the sign bit is set), load result_o, go to DONE.
- DONE: ready_o=1.
  - stall_i=1: stay in DONE, result_o and ready_o held stable.
  - stall_i=0: go to IDLE next edge; ready_o drops.
- Latency: start sampled at edge E0 → ready_o high after edge E0+33. With no stall, ready_o is high for exactly one cycle.
- stallreq_o = start_i & ~ready_o & ~annul_i (combinational). It is low in the DONE cycle so EX advances.
- busy_o = (state != IDLE).
- annul_i=1 in any state: next edge go to IDLE, ready_o=0, result_o unchanged. stallreq_o drops in the same cycle.
- start_i is ignored in CALC and DONE. Operand changes during CALC have no effect (operands latched).
- Divisor==0, architectural result (required in all builds):
  - DIV/DIVU quotient = 0xFFFFFFFF.
  - REM/REMU result = dividend.
  - Sign fixups are suppressed for this case.
- Signed overflow, dividend 0x80000000 and divisor 0xFFFFFFFF with DIV/REM: quotient = 0x80000000, remainder = 0.
- Baseline build: zero-divisor and overflow cases still take the full 33-cycle latency and produce the results above.
- Back-to-back divides: a new start is accepted only from IDLE. There is a minimum one-cycle gap (DONE→IDLE) between operations.

Optional Feature:
- Macro DIV_EARLY_OUT_EN.
- Defined, for divisor==0, signed overflow, or |dividend| < |divisor|:
  - IDLE goes directly to DONE with the final result in one edge (ready_o high after E0+1).
  - The third case gives quotient 0 and remainder = original dividend.
  - All other operations follow the normal 33-cycle path.
- Not defined: every operation takes the CALC path, 33 cycles.

Test Plan:
- DIVU 100/7: start with op=01, a=100, b=7 → after 33 cycles ready_o=1, result_o=14; stallreq_o high cycles 0-32, low in DONE.
- REM signed: op=10, a=0xFFFFFF9C (-100), b=7 → result_o=0xFFFFFFFE (-2); same with op=00 → 0xFFFFFFF2 (-14).
- Divide by zero: DIV a=0x12345678, b=0 → 0xFFFFFFFF; REMU → 0x12345678; with DIV_EARLY_OUT_EN ready_o after 1 cycle, otherwise after 33.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM → 0x00000000.
- Stall/annul:
  - Hold stall_i=1 for 5 cycles in DONE → ready_o and result_o stable all 5 cycles, IDLE one edge after stall_i falls.
  - Assert annul_i at counter=10 → IDLE next edge, ready_o never asserts.
  - A new DIVU 9/3 then returns 3.
- Reset mid-CALC: rst=0 at counter=20 → next edge all outputs 0, state IDLE; start after release yields a correct result.

Source files
------------

// File: rtl/div_unit_if.sv
// Handshake/bus bundle between the EX stage and the iterative divider.
interface div_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic            start_i;
  logic [1:0]      op_i;
  logic [XLEN-1:0] dividend_i;
  logic [XLEN-1:0] divisor_i;
  logic            annul_i;
  logic            stall_i;
  logic [XLEN-1:0] result_o;
  logic            ready_o;
  logic            busy_o;
  logic            stallreq_o;

  // EX-stage / controller side
  modport master (
    output start_i, op_i, dividend_i, divisor_i, annul_i, stall_i,
    input  result_o, ready_o, busy_o, stallreq_o
  );

  // Divider side
  modport slave (
    input  start_i, op_i, dividend_i, divisor_i, annul_i, stall_i,
    output result_o, ready_o, busy_o, stallreq_o
  );
endinterface

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Optional macro DIV_EARLY_OUT_EN: divide-by-zero, signed overflow and
// |dividend| < |divisor| finish straight from IDLE in one edge.
module div_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic      clk,
  input  logic      rst,
  div_unit_if.slave bus
);
  localparam int unsigned CW = $clog2(XLEN);
  localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      op_q, op_d;
  logic [XLEN-1:0] div_q, div_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            qneg_q, qneg_d;
  logic            rneg_q, rneg_d;
  logic            ready_q, ready_d;
  logic            busy_q, busy_d;

  // Operand magnitudes and signs for the incoming request
  logic            signed_op, a_neg, b_neg, b_zero;
  logic [XLEN-1:0] a_abs, b_abs;
  assign signed_op = ~bus.op_i[0];
  assign a_neg     = signed_op & bus.dividend_i[XLEN-1];
  assign b_neg     = signed_op & bus.divisor_i[XLEN-1];
  assign b_zero    = (bus.divisor_i == '0);
  assign a_abs     = a_neg ? ('0 - bus.dividend_i) : bus.dividend_i;
  assign b_abs     = b_neg ? ('0 - bus.divisor_i) : bus.divisor_i;

  // One restoring step; XLEN+1-bit compare covers magnitude 0x80000000
  logic [XLEN:0]   rem_sh, diff;
  logic            ge;
  logic [XLEN-1:0] rem_nx, quo_nx, quo_fix, rem_fix;
  assign rem_sh  = {rem_q, quo_q[XLEN-1]};
  assign diff    = rem_sh - {1'b0, div_q};
  assign ge      = ~diff[XLEN];
  assign rem_nx  = ge ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
  assign quo_nx  = {quo_q[XLEN-2:0], ge};
  assign quo_fix = qneg_q ? ('0 - quo_nx) : quo_nx;
  assign rem_fix = rneg_q ? ('0 - rem_nx) : rem_nx;

`ifdef DIV_EARLY_OUT_EN
  // Cases whose result is known without iterating
  logic            ovf, small, early;
  logic [XLEN-1:0] early_res;
  assign ovf   = signed_op & (bus.dividend_i == {1'b1, {(XLEN-1){1'b0}}})
                 & (&bus.divisor_i);
  assign small = (a_abs < b_abs);
  assign early = b_zero | ovf | small;
  assign early_res = bus.op_i[1] ? (ovf ? '0 : bus.dividend_i)
                   : (b_zero ? '1 : (ovf ? {1'b1, {(XLEN-1){1'b0}}} : '0));
`endif

  // Next-state and datapath control
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    div_d    = div_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    result_d = result_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    ready_d  = ready_q;

    case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          op_d    = bus.op_i;
          div_d   = b_abs;
          // Zero divisor keeps the raw dividend so REM returns it unchanged
          quo_d   = b_zero ? bus.dividend_i : a_abs;
          rem_d   = '0;
          qneg_d  = ~b_zero & (a_neg ^ b_neg);
          rneg_d  = ~b_zero & a_neg;
          cnt_d   = '0;
          state_d = CALC;
`ifdef DIV_EARLY_OUT_EN
          if (early) begin
            result_d = early_res;
            ready_d  = 1'b1;
            state_d  = DONE;
          end
`endif
        end
      end
      CALC: begin
        rem_d = rem_nx;
        quo_d = quo_nx;
        cnt_d = CW'(cnt_q + CW'(1));
        if (cnt_q == CNT_LAST) begin
          result_d = op_q[1] ? rem_fix : quo_fix;
          ready_d  = 1'b1;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (!bus.stall_i) begin
          ready_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        ready_d = 1'b0;
        state_d = IDLE;
      end
    endcase

    // Flush of the EX instruction aborts whatever is in flight
    if (bus.annul_i) begin
      ready_d = 1'b0;
      state_d = IDLE;
    end

    busy_d = (state_d != IDLE);
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      div_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      result_q <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      div_q    <= div_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      result_q <= result_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.result_o   = result_q;
  assign bus.ready_o    = ready_q;
  assign bus.busy_o     = busy_q;
  assign bus.stallreq_o = bus.start_i & ~ready_q & ~bus.annul_i;
endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit.
module tb_div_unit;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

`ifdef DIV_EARLY_OUT_EN
  localparam int LAT_SPECIAL = 1;
`else
  localparam int LAT_SPECIAL = 33;
`endif
  localparam int LAT_NORMAL = 33;

  div_unit_if #(.XLEN(32)) bus ();

  div_unit #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Issue one op with start held like EX does; measure latency, no checking here
  task automatic run_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output logic [31:0] res, output bit sr_ok,
                         output logic sr_done, output logic rdy_after);
    bus.start_i    = 1'b1;
    bus.op_i       = op;
    bus.dividend_i = a;
    bus.divisor_i  = b;
    lat   = 0;
    sr_ok = 1'b1;
    do begin
      @(negedge clk);
      lat++;
      if (bus.ready_o !== 1'b1 && bus.stallreq_o !== 1'b1) sr_ok = 1'b0;
    end while (bus.ready_o !== 1'b1 && lat < 100);
    res     = bus.result_o;
    sr_done = bus.stallreq_o;
    bus.start_i = 1'b0;
    @(negedge clk);
    rdy_after = bus.ready_o;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (bus.result_o !== 32'h0) begin errors++; $display("FAIL reset result_o: got %h expected 00000000", bus.result_o); end
    checks++; if (bus.ready_o !== 1'b0) begin errors++; $display("FAIL reset ready_o: got %b expected 0", bus.ready_o); end
    checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL reset busy_o: got %b expected 0", bus.busy_o); end
    checks++; if (bus.stallreq_o !== 1'b0) begin errors++; $display("FAIL reset stallreq_o: got %b expected 0", bus.stallreq_o); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_unsigned();
    logic [1:0] op; logic [31:0] a, b, exp, res; int lat; bit sr_ok; logic sr_done, rdy_after;
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: begin op = 2'b01; a = 32'd100;        b = 32'd7;          exp = 32'd14;         end
        1: begin op = 2'b11; a = 32'd100;        b = 32'd7;          exp = 32'd2;          end
        2: begin op = 2'b01; a = 32'hFFFF_FFFF;  b = 32'd1;          exp = 32'hFFFF_FFFF;  end
        default: begin op = 2'b11; a = 32'hFFFF_FFFF; b = 32'h8000_0000; exp = 32'h7FFF_FFFF; end
      endcase
      run_div(op, a, b, lat, res, sr_ok, sr_done, rdy_after);
      checks++; if (res !== exp) begin errors++; $display("FAIL unsigned[%0d] result: got %h expected %h", i, res, exp); end
      checks++; if (lat !== LAT_NORMAL) begin errors++; $display("FAIL unsigned[%0d] latency: got %0d expected %0d", i, lat, LAT_NORMAL); end
      if (i == 0) begin
        checks++; if (sr_ok !== 1'b1) begin errors++; $display("FAIL unsigned stallreq_busy: got %b expected 1", sr_ok); end
        checks++; if (sr_done !== 1'b0) begin errors++; $display("FAIL unsigned stallreq_done: got %b expected 0", sr_done); end
        checks++; if (rdy_after !== 1'b0) begin errors++; $display("FAIL unsigned ready_one_cycle: got %b expected 0", rdy_after); end
      end
    end
  endtask

  task automatic test_signed();
    logic [1:0] op; logic [31:0] a, b, exp, res; int lat, lat_e; bit sr_ok; logic sr_done, rdy_after;
    for (int i = 0; i < 6; i++) begin
      lat_e = LAT_NORMAL;
      case (i)
        0: begin op = 2'b10; a = 32'hFFFF_FF9C; b = 32'd7;          exp = 32'hFFFF_FFFE; end
        1: begin op = 2'b00; a = 32'hFFFF_FF9C; b = 32'd7;          exp = 32'hFFFF_FFF2; end
        2: begin op = 2'b00; a = 32'd7;         b = 32'hFFFF_FFFE;  exp = 32'hFFFF_FFFD; end
        3: begin op = 2'b10; a = 32'd7;         b = 32'hFFFF_FFFE;  exp = 32'd1;         end
        4: begin op = 2'b00; a = 32'd5;         b = 32'd7;          exp = 32'd0;         lat_e = LAT_SPECIAL; end
        default: begin op = 2'b10; a = 32'hFFFF_FFFB; b = 32'd7;    exp = 32'hFFFF_FFFB; lat_e = LAT_SPECIAL; end
      endcase
      run_div(op, a, b, lat, res, sr_ok, sr_done, rdy_after);
      checks++; if (res !== exp) begin errors++; $display("FAIL signed[%0d] result: got %h expected %h", i, res, exp); end
      checks++; if (lat !== lat_e) begin errors++; $display("FAIL signed[%0d] latency: got %0d expected %0d", i, lat, lat_e); end
    end
  endtask

  task automatic test_div_zero();
    logic [1:0] op; logic [31:0] a, exp, res; int lat; bit sr_ok; logic sr_done, rdy_after;
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: begin op = 2'b00; a = 32'h1234_5678; exp = 32'hFFFF_FFFF; end
        1: begin op = 2'b11; a = 32'h1234_5678; exp = 32'h1234_5678; end
        2: begin op = 2'b10; a = 32'hFFFF_FF9C; exp = 32'hFFFF_FF9C; end
        default: begin op = 2'b01; a = 32'h0;   exp = 32'hFFFF_FFFF; end
      endcase
      run_div(op, a, 32'h0, lat, res, sr_ok, sr_done, rdy_after);
      checks++; if (res !== exp) begin errors++; $display("FAIL div_zero[%0d] result: got %h expected %h", i, res, exp); end
      checks++; if (lat !== LAT_SPECIAL) begin errors++; $display("FAIL div_zero[%0d] latency: got %0d expected %0d", i, lat, LAT_SPECIAL); end
    end
  endtask

  task automatic test_overflow();
    logic [31:0] res; int lat; bit sr_ok; logic sr_done, rdy_after;
    run_div(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, lat, res, sr_ok, sr_done, rdy_after);
    checks++; if (res !== 32'h8000_0000) begin errors++; $display("FAIL overflow_div result: got %h expected 80000000", res); end
    checks++; if (lat !== LAT_SPECIAL) begin errors++; $display("FAIL overflow_div latency: got %0d expected %0d", lat, LAT_SPECIAL); end
    run_div(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, lat, res, sr_ok, sr_done, rdy_after);
    checks++; if (res !== 32'h0) begin errors++; $display("FAIL overflow_rem result: got %h expected 00000000", res); end
    checks++; if (lat !== LAT_SPECIAL) begin errors++; $display("FAIL overflow_rem latency: got %0d expected %0d", lat, LAT_SPECIAL); end
  endtask

  task automatic test_stall();
    int n = 0;
    bit held = 1'b1;
    bus.stall_i    = 1'b1;
    bus.start_i    = 1'b1;
    bus.op_i       = 2'b01;
    bus.dividend_i = 32'd1000;
    bus.divisor_i  = 32'd8;
    do begin @(negedge clk); n++; end while (bus.ready_o !== 1'b1 && n < 100);
    checks++; if (n !== LAT_NORMAL) begin errors++; $display("FAIL stall latency: got %0d expected %0d", n, LAT_NORMAL); end
    for (int i = 0; i < 5; i++) begin
      if (bus.ready_o !== 1'b1 || bus.result_o !== 32'd125 || bus.stallreq_o !== 1'b0) held = 1'b0;
      @(negedge clk);
    end
    checks++; if (held !== 1'b1) begin errors++; $display("FAIL stall hold: got %b expected 1", held); end
    checks++; if (bus.ready_o !== 1'b1) begin errors++; $display("FAIL stall still_ready: got %b expected 1", bus.ready_o); end
    bus.stall_i = 1'b0;
    bus.start_i = 1'b0;
    @(negedge clk);
    checks++; if (bus.ready_o !== 1'b0) begin errors++; $display("FAIL stall release_ready: got %b expected 0", bus.ready_o); end
    checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL stall release_busy: got %b expected 0", bus.busy_o); end
  endtask

  task automatic test_annul();
    logic [31:0] prev, res; int lat; bit sr_ok; logic sr_done, rdy_after;
    bit never = 1'b1;
    prev = bus.result_o;
    bus.start_i    = 1'b1;
    bus.op_i       = 2'b01;
    bus.dividend_i = 32'd1000;
    bus.divisor_i  = 32'd3;
    repeat (11) @(negedge clk);
    bus.annul_i = 1'b1;
    #1;
    checks++; if (bus.stallreq_o !== 1'b0) begin errors++; $display("FAIL annul stallreq: got %b expected 0", bus.stallreq_o); end
    checks++; if (bus.busy_o !== 1'b1) begin errors++; $display("FAIL annul busy_before: got %b expected 1", bus.busy_o); end
    @(negedge clk);
    checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL annul busy_after: got %b expected 0", bus.busy_o); end
    bus.annul_i = 1'b0;
    bus.start_i = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.ready_o !== 1'b0) never = 1'b0;
      @(negedge clk);
    end
    checks++; if (never !== 1'b1) begin errors++; $display("FAIL annul ready_never: got %b expected 1", never); end
    checks++; if (bus.result_o !== prev) begin errors++; $display("FAIL annul result_kept: got %h expected %h", bus.result_o, prev); end
    run_div(2'b01, 32'd9, 32'd3, lat, res, sr_ok, sr_done, rdy_after);
    checks++; if (res !== 32'd3) begin errors++; $display("FAIL annul next_divu result: got %h expected 00000003", res); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] res; int lat; bit sr_ok; logic sr_done, rdy_after;
    bus.start_i    = 1'b1;
    bus.op_i       = 2'b01;
    bus.dividend_i = 32'd500;
    bus.divisor_i  = 32'd5;
    repeat (21) @(negedge clk);
    rst = 1'b0;
    bus.start_i = 1'b0;
    @(negedge clk);
    checks++; if (bus.result_o !== 32'h0) begin errors++; $display("FAIL rst_mid result_o: got %h expected 00000000", bus.result_o); end
    checks++; if (bus.ready_o !== 1'b0) begin errors++; $display("FAIL rst_mid ready_o: got %b expected 0", bus.ready_o); end
    checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL rst_mid busy_o: got %b expected 0", bus.busy_o); end
    checks++; if (bus.stallreq_o !== 1'b0) begin errors++; $display("FAIL rst_mid stallreq_o: got %b expected 0", bus.stallreq_o); end
    rst = 1'b1;
    @(negedge clk);
    run_div(2'b00, 32'hFFFF_FF9C, 32'd7, lat, res, sr_ok, sr_done, rdy_after);
    checks++; if (res !== 32'hFFFF_FFF2) begin errors++; $display("FAIL rst_mid after result: got %h expected fffffff2", res); end
    checks++; if (lat !== LAT_NORMAL) begin errors++; $display("FAIL rst_mid after latency: got %0d expected %0d", lat, LAT_NORMAL); end
  endtask

  task automatic test_back_to_back();
    int n = 0;
    bus.start_i    = 1'b1;
    bus.op_i       = 2'b01;
    bus.dividend_i = 32'd20;
    bus.divisor_i  = 32'd4;
    do begin @(negedge clk); n++; end while (bus.ready_o !== 1'b1 && n < 100);
    checks++; if (bus.result_o !== 32'd5) begin errors++; $display("FAIL b2b first result: got %h expected 00000005", bus.result_o); end
    bus.dividend_i = 32'd50;
    bus.divisor_i  = 32'd5;
    @(negedge clk);
    checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL b2b gap busy: got %b expected 0", bus.busy_o); end
    checks++; if (bus.stallreq_o !== 1'b1) begin errors++; $display("FAIL b2b gap stallreq: got %b expected 1", bus.stallreq_o); end
    n = 0;
    do begin @(negedge clk); n++; end while (bus.ready_o !== 1'b1 && n < 100);
    checks++; if (n !== LAT_NORMAL) begin errors++; $display("FAIL b2b second latency: got %0d expected %0d", n, LAT_NORMAL); end
    checks++; if (bus.result_o !== 32'd10) begin errors++; $display("FAIL b2b second result: got %h expected 0000000a", bus.result_o); end
    bus.start_i = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    bus.start_i    = 1'b0;
    bus.op_i       = 2'b00;
    bus.dividend_i = 32'h0;
    bus.divisor_i  = 32'h0;
    bus.annul_i    = 1'b0;
    bus.stall_i    = 1'b0;
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_overflow();
    test_stall();
    test_annul();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
